// File: rtl/fft_spi_pkg.sv
// Shared types and defaults for the FFT result SPI link.
package fft_spi_pkg;

    localparam int unsigned FFT_N           = 32;
    localparam int unsigned FFT_MSB         = 16;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWaitCs
    } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line, with an extra flop for edge detection.
module spi_sync_edge #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic level,
    output logic rise,
    output logic fall
);

    // chain_q[Stages-1] is the synchronized level, chain_q[Stages] its previous value.
    logic [Stages:0] chain_q, chain_d;

    always_comb begin
        chain_d = {chain_q[Stages-1:0], d_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {(Stages + 1){ResetVal}};
        end else begin
            chain_q <= chain_d;
        end
    end

    always_comb begin
        level = chain_q[Stages-1];
        rise  = chain_q[Stages-1] & ~chain_q[Stages];
        fall  = ~chain_q[Stages-1] & chain_q[Stages];
    end

endmodule

// File: rtl/fft_spi_rx.sv
// SPI mode-0 slave that collects one frame of N words, MSB first, and publishes it atomically.
module fft_spi_rx
    import fft_spi_pkg::*;
#(
    parameter int unsigned N   = FFT_N,
    parameter int unsigned MSB = FFT_MSB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             cs,
    output logic [N*MSB-1:0] data_bus,
    output logic             frame_valid,
    output logic             frame_error,
    output logic             busy
);

    localparam int unsigned BitW  = $clog2(MSB);
    localparam int unsigned IdxW  = $clog2(N);
    localparam int unsigned WordW = IdxW + 1;

    localparam logic [BitW-1:0]  LastBit  = BitW'(MSB - 1);
    localparam logic [WordW-1:0] LastWord = WordW'(N - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;
    logic cs_low;

    spi_sync_edge #(
        .Stages   (SPI_SYNC_STAGES),
        .ResetVal (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .Stages   (SPI_SYNC_STAGES),
        .ResetVal (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (mosi),
        .level (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    spi_sync_edge #(
        .Stages   (SPI_SYNC_STAGES),
        .ResetVal (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign cs_low = ~cs_level;

    logic unused_sync;
    assign unused_sync = ^{sclk_level, sclk_fall, mosi_rise, mosi_fall, cs_fall};

    rx_state_e state_q, state_d;

    logic [MSB-2:0]   shift_q, shift_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WordW-1:0] word_cnt_q, word_cnt_d;
    logic [MSB-1:0]   staging_q [N];
    logic [MSB-1:0]   staging_d [N];
    logic [N*MSB-1:0] data_bus_q, data_bus_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_error_q, frame_error_d;

    logic [MSB-1:0]   word_full;
    logic [IdxW-1:0]  word_idx;
    logic             bit_take;
    logic             word_done;

    // cs_rise has priority: an sclk edge in the same cycle is dropped.
    always_comb begin
        word_full = {shift_q, mosi_s};
        word_idx  = word_cnt_q[IdxW-1:0];
        bit_take  = (state_q == StRecv) && sclk_rise && !cs_rise;
        word_done = bit_take && (bit_cnt_q == LastBit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cs_low) begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end else if (word_done && (word_cnt_q == LastWord)) begin
                    state_d = StWaitCs;
                end
            end
            StWaitCs: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        frame_valid_d = (state_q == StWaitCs) && cs_rise;
        frame_error_d = (state_q == StRecv) && cs_rise;
        busy          = (state_q != StIdle);
    end

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        staging_d  = staging_q;
        data_bus_d = data_bus_q;

        // Counters restart in IDLE, so an aborted frame leaves no trace in the next one.
        if (state_q == StIdle) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (bit_take) begin
            shift_d = word_full[MSB-2:0];
            if (word_done) begin
                staging_d[word_idx] = word_full;
                word_cnt_d          = word_cnt_q + 1'b1;
                bit_cnt_d           = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (frame_valid_d) begin
            for (int k = 0; k < int'(N); k++) begin
                data_bus_d[k*MSB +: MSB] = staging_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            staging_q     <= '{default: '0};
            data_bus_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            staging_q     <= staging_d;
            data_bus_q    <= data_bus_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data_bus    = data_bus_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_fft_spi_rx.sv
// Directed bench for fft_spi_rx: SPI master tasks plus a pulse monitor on the frame outputs.
module tb_fft_spi_rx;

    localparam int N   = 32;
    localparam int MSB = 16;
    localparam int W   = N * MSB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sclk;
    logic         mosi;
    logic         cs;
    logic [W-1:0] data_bus;
    logic         frame_valid;
    logic         frame_error;
    logic         busy;

    fft_spi_rx #(
        .N   (N),
        .MSB (MSB)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs          (cs),
        .data_bus    (data_bus),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: cycle index of each pulse and the bus seen with every frame_valid.
    int           cyc    = 0;
    int           fv_cnt = 0;
    int           fe_cnt = 0;
    int           fv_cyc = 0;
    int           fe_cyc = 0;
    logic [W-1:0] fv_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
            fv_log.push_back(data_bus);
        end
        if (frame_error) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
    end

    function automatic logic [MSB-1:0] word_of(input int kind, input int k);
        logic [15:0] kk;
        kk = 16'(k);
        case (kind)
            0:       return 16'hA500 + kk;
            1:       return kk;
            2:       return 16'hFFFF - kk;
            3:       return 16'h5A5A;
            default: return {kk[7:0], ~kk[7:0]};
        endcase
    endfunction

    function automatic logic [W-1:0] frame_of(input int kind);
        logic [W-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[k*MSB +: MSB] = word_of(kind, k);
        return f;
    endfunction

    // Mode 0 bit at SCLK = clk/8: data set while sclk is low, sampled on the rise.
    task automatic spi_bit(input logic b);
        mosi = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [MSB-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) spi_bit(w[MSB-1-i]);
    endtask

    task automatic start_frame();
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_frame(input int kind);
        for (int k = 0; k < N; k++) send_word(word_of(kind, k), MSB);
    endtask

    // Raises cs at a negedge; returns the cycle count at that moment.
    task automatic end_frame(output int c0);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        c0 = cyc;
        repeat (10) @(negedge clk);
    endtask

    int c0;
    int fv0;
    int fe0;
    logic [W-1:0] bus0;

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cs    = 1'b1;
        #1;
        check("rst_bus", data_bus, '0);
        check("rst_fv", W'(frame_valid), '0);
        check("rst_fe", W'(frame_error), '0);
        check("rst_busy", W'(busy), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Nominal frame; frame_valid three clk after the negedge on which cs went high.
        start_frame();
        check("nom_busy", W'(busy), 1);
        send_frame(0);
        check("nom_busy_wait", W'(busy), 1);
        end_frame(c0);
        check("nom_fv_cnt", W'(fv_cnt), 1);
        check("nom_fv_lat", W'(fv_cyc - c0), 3);
        check("nom_fe_cnt", W'(fe_cnt), 0);
        check("nom_bus", data_bus, frame_of(0));
        check("nom_busy_end", W'(busy), 0);

        // Aborted frame: 5 words plus 7 bits.
        fv0 = fv_cnt;
        start_frame();
        for (int k = 0; k < 5; k++) send_word(16'h1234, MSB);
        send_word(16'h1234, 7);
        end_frame(c0);
        check("abt_fe_cnt", W'(fe_cnt), 1);
        check("abt_fe_lat", W'(fe_cyc - c0), 3);
        check("abt_fv_cnt", W'(fv_cnt - fv0), 0);
        check("abt_bus", data_bus, frame_of(0));

        // Overrun: extra sclk rises after word N-1 are ignored.
        fe0 = fe_cnt;
        start_frame();
        send_frame(4);
        for (int i = 0; i < 9; i++) spi_bit(1'b1);
        end_frame(c0);
        check("ovr_fv_cnt", W'(fv_cnt - fv0), 1);
        check("ovr_fv_lat", W'(fv_cyc - c0), 3);
        check("ovr_fe_cnt", W'(fe_cnt - fe0), 0);
        check("ovr_bus", data_bus, frame_of(4));

        // Back-to-back frames with cs high for one clk in between.
        fv_log.delete();
        fv0 = fv_cnt;
        start_frame();
        send_frame(1);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        send_frame(2);
        end_frame(c0);
        check("b2b_fv_cnt", W'(fv_cnt - fv0), 2);
        check("b2b_f0", (fv_log.size() > 0) ? fv_log[0] : '0, frame_of(1));
        check("b2b_f1", (fv_log.size() > 1) ? fv_log[1] : '0, frame_of(2));
        check("b2b_fe_cnt", W'(fe_cnt - fe0), 0);

        // Asynchronous reset during word 10.
        start_frame();
        for (int k = 0; k < 10; k++) send_word(word_of(0, k), MSB);
        send_word(word_of(0, 10), 5);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_bus", data_bus, '0);
        check("mrst_busy", W'(busy), 0);
        check("mrst_fv", W'(frame_valid), 0);
        check("mrst_fe", W'(frame_error), 0);
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        start_frame();
        send_frame(3);
        end_frame(c0);
        check("post_rst_fv", W'(fv_cnt - fv0), 1);
        check("post_rst_bus", data_bus, frame_of(3));

        // sclk toggling with cs high must not start a frame.
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        bus0 = data_bus;
        for (int i = 0; i < 3; i++) begin
            spi_bit(1'b1);
            check("glitch_busy", W'(busy), 0);
        end
        check("glitch_fv", W'(fv_cnt - fv0), 0);
        check("glitch_fe", W'(fe_cnt - fe0), 0);

        // cs rise in the same cycle as the final sclk rise of word N-1: error wins.
        start_frame();
        for (int k = 0; k < N - 1; k++) send_word(word_of(1, k), MSB);
        send_word(word_of(1, N - 1), MSB - 1);
        mosi = word_of(1, N - 1) & 16'h0001;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        cs   = 1'b1;
        c0   = cyc;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        check("prio_fe_cnt", W'(fe_cnt - fe0), 1);
        check("prio_fe_lat", W'(fe_cyc - c0), 3);
        check("prio_fv_cnt", W'(fv_cnt - fv0), 0);
        check("prio_bus", data_bus, bus0);
        check("prio_busy", W'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
